// File: rtl/wb_stage_queued.sv
// Queued writeback stage: buffers retiring MEM results in an in-order ring,
// drains them into a back-pressured register-file write port and raises precise flushes.
module wb_stage_queued #(
  parameter int DATA_W   = 32,
  parameter int RF_AW    = 5,
  parameter int PC_W     = 32,
  parameter int ECODE_W  = 6,
  parameter int DEPTH    = 4,
  parameter int MS_BUS_W = PC_W + 1 + RF_AW + DATA_W + 1 + ECODE_W
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ms_to_ws_valid,
  output logic                      ws_allow_in,
  input  logic [MS_BUS_W-1:0]       ms_to_ws_bus,
  output logic                      rf_we,
  output logic [RF_AW-1:0]          rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      rf_wready,
  output logic [1+RF_AW+DATA_W-1:0] ws_to_ds_bus,
  output logic                      ws_pending,
  output logic                      ws_flush,
  output logic [PC_W-1:0]           ws_ex_pc,
  output logic [ECODE_W-1:0]        ws_ex_code,
  output logic [PC_W-1:0]           debug_wb_pc,
  output logic [DATA_W/8-1:0]       debug_wb_rf_we,
  output logic [RF_AW-1:0]          debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int OFF_WE   = PC_W;
  localparam int OFF_DEST = PC_W + 1;
  localparam int OFF_DATA = OFF_DEST + RF_AW;
  localparam int OFF_EX   = OFF_DATA + DATA_W;
  localparam int OFF_CODE = OFF_EX + 1;

  logic [MS_BUS_W-1:0] entry_mem [DEPTH];
  logic [DEPTH-1:0]    valid_reg, valid_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                flush_reg;
  logic [PC_W-1:0]     ex_pc_reg;
  logic [ECODE_W-1:0]  ex_code_reg;

  logic [MS_BUS_W-1:0] head_bus;
  logic                head_valid, head_ex, head_gr_we;
  logic                push, pop, take_ex;
  logic [DEPTH-1:0]    entry_fwd;

  assign head_bus   = entry_mem[rd_ptr_reg];
  assign head_valid = valid_reg[rd_ptr_reg];
  assign head_ex    = head_valid && head_bus[OFF_EX];
  assign head_gr_we = head_valid && head_bus[OFF_WE];

  assign ws_allow_in = (count_reg != CNT_W'(DEPTH)) && !flush_reg;
  assign push        = ms_to_ws_valid && ws_allow_in;
  assign take_ex     = head_ex;
  // A pending write holds the head until the port accepts it; everything else leaves at once.
  assign pop         = head_valid && (head_ex || !head_gr_we || rf_wready);

  assign rf_we    = head_gr_we && !head_ex;
  assign rf_waddr = head_valid ? head_bus[OFF_DEST +: RF_AW] : '0;
  assign rf_wdata = head_valid ? head_bus[OFF_DATA +: DATA_W] : '0;

  assign ws_to_ds_bus = {rf_we, rf_waddr, rf_wdata};

  // Hazard flag looks only behind the head; the head itself is visible on the forwarding bus.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
      assign entry_fwd[gi] = valid_reg[gi] && entry_mem[gi][OFF_WE] && !entry_mem[gi][OFF_EX]
                             && (PTR_W'(gi) != rd_ptr_reg);
    end
  endgenerate
  assign ws_pending = |entry_fwd;

  assign ws_flush   = flush_reg;
  assign ws_ex_pc   = ex_pc_reg;
  assign ws_ex_code = ex_code_reg;

  assign debug_wb_rf_we    = {(DATA_W/8){rf_we && rf_wready}};
  assign debug_wb_pc       = head_valid ? head_bus[PC_W-1:0] : '0;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  always_comb begin
    valid_next  = valid_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (take_ex) begin
      // Exception at the head squashes the whole queue, including a same-cycle push.
      valid_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (pop) begin
        valid_next[rd_ptr_reg] = 1'b0;
        rd_ptr_next            = rd_ptr_reg + PTR_W'(1);
      end
      if (push) begin
        valid_next[wr_ptr_reg] = 1'b1;
        wr_ptr_next            = wr_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      flush_reg   <= 1'b0;
      ex_pc_reg   <= '0;
      ex_code_reg <= '0;
    end else begin
      valid_reg   <= valid_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      flush_reg   <= take_ex;
      ex_pc_reg   <= take_ex ? head_bus[PC_W-1:0] : '0;
      ex_code_reg <= take_ex ? head_bus[OFF_CODE +: ECODE_W] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entry_mem[wr_ptr_reg] <= ms_to_ws_bus;
  end

endmodule
